// File: rtl/vga_sync_timing_module_pkg.sv
// Shared SVGA 800x600 @ 40 MHz timing constants and counter types.
// The downstream pixel/ROM control stage uses the same offsets.
`timescale 1ns/1ps
package vga_timing_pkg;
    localparam int unsigned H_SYNC   = 128;
    localparam int unsigned H_BP     = 88;
    localparam int unsigned H_ACT    = 800;
    localparam int unsigned H_FP     = 40;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 23;
    localparam int unsigned V_ACT    = 600;
    localparam int unsigned V_FP     = 1;
    localparam logic        SYNC_POL = 1'b0;
    localparam int unsigned PIPE_DLY = 3;

    localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_ACT_START = H_SYNC + H_BP + 1;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP + 1;

    typedef logic [10:0] col_t;
    typedef logic [9:0]  row_t;
endpackage

// File: rtl/vga_sync_timing_module_if.sv
// Raster timing bundle: counters, delayed syncs and undelayed status flags.
`timescale 1ns/1ps
interface vga_sync_timing_module_if;
    import vga_timing_pkg::*;

    col_t qC1;
    row_t qC2;
    logic HSYNC_Sig;
    logic VSYNC_Sig;
    logic Active_Sig;
    logic Frame_Start;

    modport master (output qC1, qC2, HSYNC_Sig, VSYNC_Sig, Active_Sig, Frame_Start);
    modport slave  (input  qC1, qC2, HSYNC_Sig, VSYNC_Sig, Active_Sig, Frame_Start);
endinterface

// File: rtl/vga_sync_timing_module_delay.sv
// 1-bit shift register; output equals the input DEPTH clocks earlier.
`timescale 1ns/1ps
module sync_delay_line #(
    parameter int unsigned DEPTH   = 3,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] tap_q;
    logic [DEPTH-1:0] tap_d;

    always_comb begin
        tap_d    = tap_q << 1;
        tap_d[0] = din;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tap_q <= {DEPTH{RST_VAL}};
        end else begin
            tap_q <= tap_d;
        end
    end

    assign dout = tap_q[DEPTH-1];
endmodule

// File: rtl/vga_sync_timing_module.sv
// SVGA raster counters with pipeline-aligned sync outputs.
`timescale 1ns/1ps
module vga_sync_timing_module #(
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned H_ACT    = vga_timing_pkg::H_ACT,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned V_ACT    = vga_timing_pkg::V_ACT,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter logic        SYNC_POL = vga_timing_pkg::SYNC_POL,
    parameter int unsigned PIPE_DLY = vga_timing_pkg::PIPE_DLY
) (
    input  logic                             CLK,
    input  logic                             RSTn,
    vga_sync_timing_module_if.master         vga
);
    import vga_timing_pkg::*;

    // All region bounds held at 11 bits; rows are zero-extended to compare.
    localparam col_t H_SYNC_END = col_t'(H_SYNC);
    localparam col_t H_ACT_LO   = col_t'(H_SYNC + H_BP);
    localparam col_t H_ACT_HI   = col_t'(H_SYNC + H_BP + H_ACT);
    localparam col_t H_TOT      = col_t'(H_SYNC + H_BP + H_ACT + H_FP);
    localparam col_t V_SYNC_END = col_t'(V_SYNC);
    localparam col_t V_ACT_LO   = col_t'(V_SYNC + V_BP);
    localparam col_t V_ACT_HI   = col_t'(V_SYNC + V_BP + V_ACT);
    localparam col_t V_TOT      = col_t'(V_SYNC + V_BP + V_ACT + V_FP);

    col_t col_q, col_d;
    row_t row_q, row_d;
    col_t row_x;
    logic h_raw, v_raw;

    always_comb begin
        col_d = col_q + col_t'(1);
        row_d = row_q;
        if (col_q == H_TOT) begin
            col_d = col_t'(1);
            row_d = (row_x == V_TOT) ? row_t'(1) : row_q + row_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            col_q <= col_t'(1);
            row_q <= row_t'(1);
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        row_x = col_t'(row_q);
        h_raw = (col_q <= H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        v_raw = (row_x <= V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    end

    sync_delay_line #(.DEPTH(PIPE_DLY), .RST_VAL(~SYNC_POL)) u_h_dly (
        .CLK  (CLK),
        .RSTn (RSTn),
        .din  (h_raw),
        .dout (vga.HSYNC_Sig)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .RST_VAL(~SYNC_POL)) u_v_dly (
        .CLK  (CLK),
        .RSTn (RSTn),
        .din  (v_raw),
        .dout (vga.VSYNC_Sig)
    );

    assign vga.qC1         = col_q;
    assign vga.qC2         = row_q;
    assign vga.Active_Sig  = (col_q > H_ACT_LO) && (col_q <= H_ACT_HI) &&
                             (row_x > V_ACT_LO) && (row_x <= V_ACT_HI);
    assign vga.Frame_Start = (col_q == col_t'(1)) && (row_q == row_t'(1));
endmodule

// File: tb/tb_vga_sync_timing_module.sv
// Bench for vga_sync_timing_module: default, PIPE_DLY=1 and a reduced-raster instance.
`timescale 1ns/1ps
module tb_vga_sync_timing_module;
    typedef struct packed {
        logic [10:0] c;
        logic [9:0]  r;
        logic        hs;
        logic        vs;
        logic        act;
        logic        fs;
    } obs_t;

    typedef struct {
        int unsigned n;
        obs_t        exp;
    } vec_t;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    vga_sync_timing_module_if if_d ();
    vga_sync_timing_module_if if_p1 ();
    vga_sync_timing_module_if if_s ();

    vga_sync_timing_module dut (.CLK(CLK), .RSTn(RSTn), .vga(if_d));
    vga_sync_timing_module #(.PIPE_DLY(1)) dut_p1 (.CLK(CLK), .RSTn(RSTn), .vga(if_p1));
    vga_sync_timing_module #(
        .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACT(4), .V_FP(1),
        .PIPE_DLY(5)
    ) dut_s (.CLK(CLK), .RSTn(RSTn), .vga(if_s));

    int n_chk  = 0;
    int n_fail = 0;

    vec_t        tbl [16];
    int unsigned ti;
    bit          phase1;
    int unsigned hs_low_cnt;
    int          first_fall_d, first_fall_p1;
    bit          have_fs;
    int unsigned last_fs, act_acc, vs_acc;

    task automatic chk(input string name, input int unsigned n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d actual=%0d required=%0d", name, n, act, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input int unsigned n, input obs_t a, input obs_t e);
        chk({tag, ".qC1"},   n, 32'(a.c),   32'(e.c));
        chk({tag, ".qC2"},   n, 32'(a.r),   32'(e.r));
        chk({tag, ".hsync"}, n, 32'(a.hs),  32'(e.hs));
        chk({tag, ".vsync"}, n, 32'(a.vs),  32'(e.vs));
        chk({tag, ".active"},n, 32'(a.act), 32'(e.act));
        chk({tag, ".fstart"},n, 32'(a.fs),  32'(e.fs));
    endtask

    // Reference: cycle n after reset release mapped onto the raster arithmetically.
    function automatic obs_t model(input int unsigned n, input int unsigned hsw, hbp, hact, hfp,
                                   input int unsigned vsw, vbp, vact, vfp, dly);
        int unsigned ht, vt, col, row, pc, pr;
        obs_t m;
        ht  = hsw + hbp + hact + hfp;
        vt  = vsw + vbp + vact + vfp;
        col = n % ht + 1;
        row = (n / ht) % vt + 1;
        m.c   = 11'(col);
        m.r   = 10'(row);
        m.act = (col > hsw + hbp) && (col <= hsw + hbp + hact) &&
                (row > vsw + vbp) && (row <= vsw + vbp + vact);
        m.fs  = (n % (ht * vt)) == 0;
        if (n < dly) begin
            m.hs = 1'b1;
            m.vs = 1'b1;
        end else begin
            pc   = (n - dly) % ht + 1;
            pr   = ((n - dly) / ht) % vt + 1;
            m.hs = (pc > hsw);
            m.vs = (pr > vsw);
        end
        return m;
    endfunction

    function automatic obs_t grab_d();
        return obs_t'{if_d.qC1, if_d.qC2, if_d.HSYNC_Sig, if_d.VSYNC_Sig, if_d.Active_Sig, if_d.Frame_Start};
    endfunction
    function automatic obs_t grab_p1();
        return obs_t'{if_p1.qC1, if_p1.qC2, if_p1.HSYNC_Sig, if_p1.VSYNC_Sig, if_p1.Active_Sig, if_p1.Frame_Start};
    endfunction
    function automatic obs_t grab_s();
        return obs_t'{if_s.qC1, if_s.qC2, if_s.HSYNC_Sig, if_s.VSYNC_Sig, if_s.Active_Sig, if_s.Frame_Start};
    endfunction

    task automatic chk_reset(input string tag);
        obs_t r;
        r = obs_t'{11'd1, 10'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        chk_obs({tag, ".d"},  0, grab_d(),  r);
        chk_obs({tag, ".p1"}, 0, grab_p1(), r);
        chk_obs({tag, ".s"},  0, grab_s(),  r);
    endtask

    task automatic monitor(input int unsigned n);
        obs_t s;
        chk_obs("model.d",  n, grab_d(),  model(n, 128, 88, 800, 40, 4, 23, 600, 1, 3));
        chk_obs("model.p1", n, grab_p1(), model(n, 128, 88, 800, 40, 4, 23, 600, 1, 1));
        s = grab_s();
        chk_obs("model.s",  n, s,         model(n, 3, 2, 6, 2, 2, 1, 4, 1, 5));

        // Reduced raster: 13x8 = 104 clocks per frame, 24 active, 26 vsync-low.
        if (n % 104 == 0) begin
            act_acc = 0;
            vs_acc  = 0;
        end
        act_acc += 32'(s.act);
        vs_acc  += 32'(!s.vs);
        if (n % 104 == 103) begin
            chk("s.active_per_frame", n, act_acc, 24);
            chk("s.vsync_low_per_frame", n, vs_acc, 26);
        end
        if (s.fs) begin
            if (have_fs) chk("s.fstart_period", n, n - last_fs, 104);
            have_fs = 1'b1;
            last_fs = n;
        end

        if (phase1) begin
            if (ti < 16 && n == tbl[ti].n) begin
                chk_obs("vec", n, grab_d(), tbl[ti].exp);
                ti++;
            end
            if (n < 1056) begin
                if (!if_d.HSYNC_Sig) begin
                    hs_low_cnt++;
                    if (first_fall_d < 0) first_fall_d = int'(n);
                end
                if (!if_p1.HSYNC_Sig && first_fall_p1 < 0) first_fall_p1 = int'(n);
            end
        end
    endtask

    // Releases reset at the current negedge and checks cycles 0..cycles-1.
    task automatic run_from_release(input int unsigned cycles);
        RSTn    = 1'b1;
        have_fs = 1'b0;
        for (int unsigned n = 0; n < cycles; n++) begin
            if (n > 0) @(negedge CLK);
            monitor(n);
        end
    endtask

    task automatic async_reset(input string tag, input int unsigned offs, input int unsigned hold);
        @(negedge CLK);
        #(offs);
        RSTn = 1'b0;
        #1;
        chk_reset(tag);
        repeat (hold) @(negedge CLK);
        chk_reset({tag, ".held"});
    endtask

    initial begin
        //                  n      qC1   qC2  hs vs act fs
        tbl[0]  = '{0,     obs_t'{11'd1,    10'd1,  1'b1, 1'b1, 1'b0, 1'b1}};
        tbl[1]  = '{1,     obs_t'{11'd2,    10'd1,  1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[2]  = '{2,     obs_t'{11'd3,    10'd1,  1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{3,     obs_t'{11'd4,    10'd1,  1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[4]  = '{130,   obs_t'{11'd131,  10'd1,  1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{131,   obs_t'{11'd132,  10'd1,  1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{1055,  obs_t'{11'd1056, 10'd1,  1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[7]  = '{1056,  obs_t'{11'd1,    10'd2,  1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[8]  = '{1059,  obs_t'{11'd4,    10'd2,  1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{4226,  obs_t'{11'd3,    10'd5,  1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[10] = '{4227,  obs_t'{11'd4,    10'd5,  1'b0, 1'b1, 1'b0, 1'b0}};
        tbl[11] = '{27955, obs_t'{11'd500,  10'd27, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[12] = '{28727, obs_t'{11'd216,  10'd28, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[13] = '{28728, obs_t'{11'd217,  10'd28, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[14] = '{29527, obs_t'{11'd1016, 10'd28, 1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[15] = '{29528, obs_t'{11'd1017, 10'd28, 1'b1, 1'b1, 1'b0, 1'b0}};

        ti            = 0;
        hs_low_cnt    = 0;
        first_fall_d  = -1;
        first_fall_p1 = -1;
        have_fs       = 1'b0;
        last_fs       = 0;
        act_acc       = 0;
        vs_acc        = 0;

        repeat (3) @(negedge CLK);
        chk_reset("por");

        // Long run up to qC1=500 on row 29 (n = 28*1056 + 499).
        phase1 = 1'b1;
        run_from_release(30068);
        phase1 = 1'b0;
        chk("vectors_applied", 0, ti, 16);
        chk("hsync_low_clocks", 0, hs_low_cnt, 128);
        chk("hsync_fall_dly3", 0, 32'(first_fall_d), 3);
        chk("hsync_fall_dly1", 0, 32'(first_fall_p1), 1);
        chk("pre_reset_col", 0, 32'(if_d.qC1), 500);

        async_reset("async_mid", 2, 2);
        @(negedge CLK);
        run_from_release(1200);

        for (int it = 0; it < 6; it++) begin
            async_reset("async_rand", $urandom_range(1, 4), $urandom_range(1, 3));
            @(negedge CLK);
            run_from_release($urandom_range(100, 2500));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
